// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter: direction encoding and legal width range.
package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int SIZE_MIN = 2;
  localparam int SIZE_MAX = 32;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and boundary-pulse logic for updown_counter.
// The saturate input is tied low by the top unless UPDOWN_COUNTER_SATURATE_EN is defined.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int Size = 5
) (
  input  logic [Size-1:0] count,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic            enable,
  input  logic            up,
  input  logic [Size-1:0] limit,
  input  logic            saturate,
  output logic [Size-1:0] next_count,
  output logic            next_terminal
);

  localparam logic [Size-1:0] ONE = Size'(1);

  always_comb begin
    next_count    = count;
    next_terminal = 1'b0;
    if (load) begin
      next_count = load_value;
    end else if (enable) begin
      if (up == DIR_UP) begin
        // A count already above limit is treated as a boundary, so it never runs past the modulus.
        if (count < limit) begin
          next_count = count + ONE;
        end else begin
          next_count    = saturate ? limit : '0;
          next_terminal = 1'b1;
        end
      end else begin
        if (count != '0) begin
          next_count = count - ONE;
        end else begin
          next_count    = saturate ? '0 : limit;
          next_terminal = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Modulo-(limit+1) up/down counter with synchronous load and a registered boundary pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to add the saturate input (hold at the boundary instead of wrapping).
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int Size       = 5,
  parameter int ResetValue = 0
) (
  input  logic            clock,
  input  logic            reset,
`ifdef UPDOWN_COUNTER_SATURATE_EN
  input  logic            saturate,
`endif
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic [Size-1:0] limit,
  output logic [Size-1:0] count,
  output logic            terminal
);

  localparam logic [Size-1:0] RESET_COUNT = Size'(ResetValue);

  if (Size < SIZE_MIN || Size > SIZE_MAX) begin : g_bad_size
    $error("updown_counter: Size out of range");
  end
  if (ResetValue < 0 || longint'(ResetValue) >= (64'sd1 <<< Size)) begin : g_bad_reset
    $error("updown_counter: ResetValue does not fit in Size bits");
  end

  logic            sat_mode;
  logic [Size-1:0] next_count;
  logic            next_terminal;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  assign sat_mode = saturate;
`else
  assign sat_mode = 1'b0;
`endif

  updown_counter_next #(.Size(Size)) u_next (
    .count         (count),
    .load          (load),
    .load_value    (load_value),
    .enable        (enable),
    .up            (up),
    .limit         (limit),
    .saturate      (sat_mode),
    .next_count    (next_count),
    .next_terminal (next_terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= RESET_COUNT;
      terminal <= 1'b0;
    end else begin
      count    <= next_count;
      terminal <= next_terminal;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter (Size=5, ResetValue=0): directed scenarios then random traffic.
// Builds with or without UPDOWN_COUNTER_SATURATE_EN.
module tb_updown_counter;

  localparam int W = 5;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] limit;
  logic         saturate;
  logic [W-1:0] count;
  logic         terminal;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_count;
  bit m_term;
  logic [W:0] exp_q[$];

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  updown_counter #(.Size(W), .ResetValue(0)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef UPDOWN_COUNTER_SATURATE_EN
    .saturate   (saturate),
`endif
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .count      (count),
    .terminal   (terminal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge per the counter rules, in plain integers.
  function automatic void model_edge();
    int  lim;
    bit  sat;
    lim = int'(limit);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    sat = saturate;
`else
    sat = 1'b0;
`endif
    if (load) begin
      m_count = int'(load_value);
      m_term  = 1'b0;
    end else if (!enable) begin
      m_term = 1'b0;
    end else if (up) begin
      if (m_count < lim) begin
        m_count = m_count + 1;
        m_term  = 1'b0;
      end else begin
        m_count = sat ? lim : 0;
        m_term  = 1'b1;
      end
    end else begin
      if (m_count != 0) begin
        m_count = m_count - 1;
        m_term  = 1'b0;
      end else begin
        m_count = sat ? 0 : lim;
        m_term  = 1'b1;
      end
    end
  endfunction

  // driver: inputs are already set; run one edge and score it
  task automatic cycle(input string tag);
    logic [W:0] e;
    model_edge();
    exp_q.push_back({m_term, W'(m_count)});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({tag, ".count"}, 32'(count), 32'(e[W-1:0]));
    check({tag, ".term"}, 32'(terminal), 32'(e[W]));
  endtask

  task automatic set_in(input bit l, input int lv, input bit en, input bit u, input int lim);
    load       = l;
    load_value = W'(lv);
    enable     = en;
    up         = u;
    limit      = W'(lim);
  endtask

  // assert reset between edges; outputs must clear without a clock edge
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    check({tag, ".async_count"}, 32'(count), 32'd0);
    check({tag, ".async_term"}, 32'(terminal), 32'd0);
    @(posedge clock);
    #1;
    check({tag, ".held_count"}, 32'(count), 32'd0);
    reset   = 1'b1;
    m_count = 0;
    m_term  = 1'b0;
  endtask

  initial begin
    int seq32[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int seq33[5]  = '{2, 1, 0, 9, 8};

    reset    = 1'b0;
    saturate = 1'b0;
    set_in(1'b0, 0, 1'b0, 1'b1, 9);
    #12;
    check("reset.count", 32'(count), 32'd0);
    check("reset.term", 32'(terminal), 32'd0);
    reset   = 1'b1;
    m_count = 0;
    m_term  = 1'b0;

    // count up with limit 9: wraps after 9
    set_in(1'b0, 0, 1'b1, 1'b1, 9);
    for (int i = 0; i < 12; i++) begin
      cycle("up9");
      check("up9.seq", 32'(count), 32'(seq32[i]));
      check("up9.pulse", 32'(terminal), 32'(seq32[i] == 0));
    end

    // load 3 then count down through the zero boundary
    set_in(1'b1, 3, 1'b0, 1'b0, 9);
    cycle("load3");
    set_in(1'b0, 0, 1'b1, 1'b0, 9);
    for (int i = 0; i < 5; i++) begin
      cycle("down9");
      check("down9.seq", 32'(count), 32'(seq33[i]));
      check("down9.pulse", 32'(terminal), 32'(seq33[i] == 9));
    end

    // load wins over enable; an out-of-range value wraps on the next up step
    set_in(1'b1, 20, 1'b1, 1'b1, 9);
    cycle("load20");
    check("load20.lit", 32'(count), 32'd20);
    set_in(1'b0, 0, 1'b1, 1'b1, 9);
    cycle("over");
    check("over.lit", 32'(count), 32'd0);
    check("over.pulse", 32'(terminal), 32'd1);

    // down step from above limit just decrements
    set_in(1'b1, 25, 1'b0, 1'b0, 9);
    cycle("load25");
    set_in(1'b0, 0, 1'b1, 1'b0, 9);
    cycle("down_over");
    check("down_over.lit", 32'(count), 32'd24);

    // asynchronous reset at count 7
    set_in(1'b1, 7, 1'b0, 1'b1, 9);
    cycle("load7");
    set_in(1'b0, 0, 1'b1, 1'b1, 9);
    async_reset("rst7");

    // full-range wrap at limit 31
    set_in(1'b1, 31, 1'b0, 1'b1, 31);
    cycle("load31");
    set_in(1'b0, 0, 1'b1, 1'b1, 31);
    cycle("wrap31");
    check("wrap31.lit", 32'(count), 32'd0);
    check("wrap31.pulse", 32'(terminal), 32'd1);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    saturate = 1'b1;
    set_in(1'b1, 31, 1'b0, 1'b1, 31);
    cycle("sload31");
    set_in(1'b0, 0, 1'b1, 1'b1, 31);
    cycle("sat31");
    check("sat31.lit", 32'(count), 32'd31);
    check("sat31.pulse", 32'(terminal), 32'd1);
    set_in(1'b1, 0, 1'b0, 1'b0, 31);
    cycle("sload0");
    set_in(1'b0, 0, 1'b1, 1'b0, 31);
    cycle("sat0");
    check("sat0.lit", 32'(count), 32'd0);
    saturate = 1'b0;
`endif

    // limit 0: every enabled edge is a boundary in both directions
    set_in(1'b1, 0, 1'b0, 1'b1, 0);
    cycle("load0");
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 0, 1'b1, (i % 2) == 0, 0);
      cycle("lim0");
      check("lim0.lit", 32'(count), 32'd0);
      check("lim0.pulse", 32'(terminal), 32'd1);
    end

    // idle edge holds and clears the pulse
    set_in(1'b0, 0, 1'b0, 1'b1, 0);
    cycle("idle");
    check("idle.pulse", 32'(terminal), 32'd0);

    // randomized traffic
    limit = W'($urandom_range(0, 31));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        enable = 1'b1;
        async_reset("rnd_rst");
      end else begin
        load       = ($urandom_range(0, 99) < 8);
        load_value = W'($urandom_range(0, 31));
        enable     = ($urandom_range(0, 99) < 75);
        up         = W'($urandom_range(0, 1)) != 0;
        if ($urandom_range(0, 99) < 6)
          limit = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 31));
`ifdef UPDOWN_COUNTER_SATURATE_EN
        saturate = ($urandom_range(0, 99) < 30);
`endif
        cycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
